// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// registers the fetched word, its PC and a pre-decoded format code for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall_in,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst_out,
    output logic [31:0] o_pc_out,
    output logic [2:0]  o_inst_format,
    output logic        o_illegal_op
);

    localparam logic [2:0] IFORMAT_R  = 3'd0;
    localparam logic [2:0] IFORMAT_I  = 3'd1;
    localparam logic [2:0] IFORMAT_S  = 3'd2;
    localparam logic [2:0] IFORMAT_SB = 3'd3;
    localparam logic [2:0] IFORMAT_U  = 3'd4;
    localparam logic [2:0] IFORMAT_UJ = 3'd5;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_saved, w_saved_nxt;
    logic        r_inst_valid;
    logic [31:0] r_inst_out;
    logic [31:0] r_pc_out;
    logic [2:0]  r_inst_format;
    logic        r_illegal_op;

    logic        w_req;
    logic        w_accept;
    logic [31:0] w_target;
    logic [2:0]  w_fmt;
    logic        w_ill;

    assign w_target = i_redirect_pc & ~32'd3;

    always_comb begin
        w_req = 1'b0;
        case (r_state)
            ST_RUN:   w_req = !r_inst_valid || !i_stall_in;
            ST_DRAIN: w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
    end

    // A redirect discards whatever memory returns in the same cycle.
    assign w_accept = (r_state == ST_RUN) && w_req && i_imem_ready && !i_redirect_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_saved_nxt = r_saved;
        if (i_redirect_valid) begin
            if (w_req && !i_imem_ready) begin
                w_state_nxt = ST_DRAIN;
                w_saved_nxt = w_target;
            end else begin
                w_state_nxt = ST_RUN;
                w_pc_nxt    = w_target;
            end
        end else begin
            case (r_state)
                ST_BOOT: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_accept) w_pc_nxt = r_pc + 32'd4;
                end
                ST_DRAIN: begin
                    if (i_imem_ready) begin
                        w_state_nxt = ST_RUN;
                        w_pc_nxt    = r_saved;
                    end
                end
                default: w_state_nxt = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        w_fmt = IFORMAT_R;
        w_ill = 1'b0;
        case (i_imem_rdata[6:0])
            7'b0110011: w_fmt = IFORMAT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111: w_fmt = IFORMAT_I;
            7'b0100011: w_fmt = IFORMAT_S;
            7'b1100011: w_fmt = IFORMAT_SB;
            7'b0110111, 7'b0010111: w_fmt = IFORMAT_U;
            7'b1101111: w_fmt = IFORMAT_UJ;
            default:    w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC & ~32'd3;
            r_saved       <= 32'd0;
            r_inst_valid  <= 1'b0;
            r_inst_out    <= 32'd0;
            r_pc_out      <= 32'd0;
            r_inst_format <= IFORMAT_R;
            r_illegal_op  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_saved <= w_saved_nxt;
            if (i_redirect_valid) begin
                r_inst_valid <= 1'b0;
            end else if (w_accept) begin
                r_inst_valid  <= 1'b1;
                r_inst_out    <= i_imem_rdata;
                r_pc_out      <= r_pc;
                r_inst_format <= w_fmt;
                r_illegal_op  <= w_ill;
            end else if (!(i_stall_in && r_inst_valid)) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_pc;
    assign o_inst_valid  = r_inst_valid;
    assign o_inst_out    = r_inst_out;
    assign o_pc_out      = r_pc_out;
    assign o_inst_format = r_inst_format;
    assign o_illegal_op  = r_illegal_op;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (default and wrapping reset PC) checked
// every cycle against a transaction-level model plus directed literal checks.
module tb_fetch_stage;

    localparam logic [2:0] IF_R  = 3'd0;
    localparam logic [2:0] IF_I  = 3'd1;
    localparam logic [2:0] IF_S  = 3'd2;
    localparam logic [2:0] IF_SB = 3'd3;
    localparam logic [2:0] IF_U  = 3'd4;
    localparam logic [2:0] IF_UJ = 3'd5;
    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ready, stall, redir;
    logic [31:0] rpc;

    logic        req0, v0, ill0, req1, v1, ill1;
    logic [31:0] addr0, inst0, pco0, rdata0, addr1, inst1, pco1, rdata1;
    logic [2:0]  fmt0, fmt1;

    int n_checks = 0;
    int n_err    = 0;

    logic [6:0] opc_tab [16] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                 7'b1110011, 7'b0001111, 7'b0100011, 7'b1100011,
                                 7'b0110111, 7'b0010111, 7'b1101111, 7'h7F,
                                 7'h00, 7'b0110010, 7'b1011011, 7'b0000111};

    function automatic logic [31:0] mem_word(int k, logic [31:0] a);
        if (k == 0 && a == 32'h0) return 32'h0050_0093;
        if (k == 0 && a == 32'h4) return 32'h0020_8133;
        if (k == 0 && a == 32'h8) return 32'h00A1_2023;
        if (k == 1 && a == 32'hFFFF_FFFC) return 32'h0000_006F;
        if (k == 1 && a == 32'h0) return 32'h0000_007F;
        return {a[26:2] ^ 25'h15A_5A5A, opc_tab[a[5:2] ^ a[9:6]]};
    endfunction

    assign rdata0 = mem_word(0, addr0);
    assign rdata1 = mem_word(1, addr1);

    fetch_stage #(.RESET_PC(RPC0)) dut0 (
        .i_clk(clk), .i_rst(rst), .o_imem_req(req0), .o_imem_addr(addr0),
        .i_imem_ready(ready), .i_imem_rdata(rdata0), .i_stall_in(stall),
        .i_redirect_valid(redir), .i_redirect_pc(rpc), .o_inst_valid(v0),
        .o_inst_out(inst0), .o_pc_out(pco0), .o_inst_format(fmt0), .o_illegal_op(ill0));

    fetch_stage #(.RESET_PC(RPC1)) dut1 (
        .i_clk(clk), .i_rst(rst), .o_imem_req(req1), .o_imem_addr(addr1),
        .i_imem_ready(ready), .i_imem_rdata(rdata1), .i_stall_in(stall),
        .i_redirect_valid(redir), .i_redirect_pc(rpc), .o_inst_valid(v1),
        .o_inst_out(inst1), .o_pc_out(pco1), .o_inst_format(fmt1), .o_illegal_op(ill1));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: fetch pointer, pending-discard target, and the IF/ID slot.
    typedef struct packed {
        logic        boot;
        logic        drain;
        logic        valid;
        logic        ill;
        logic [2:0]  fmt;
        logic [31:0] pc;
        logic [31:0] saved;
        logic [31:0] inst;
        logic [31:0] pcout;
    } mdl_t;

    mdl_t m0, m1;

    function automatic logic m_req(mdl_t s);
        if (s.boot) return 1'b0;
        if (s.drain) return 1'b1;
        return !s.valid || !stall;
    endfunction

    function automatic void classify(logic [6:0] op, output logic [2:0] f, output logic il);
        il = 1'b0;
        if (op == 7'b0110011) f = IF_R;
        else if (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111}) f = IF_I;
        else if (op == 7'b0100011) f = IF_S;
        else if (op == 7'b1100011) f = IF_SB;
        else if (op inside {7'b0110111, 7'b0010111}) f = IF_U;
        else if (op == 7'b1101111) f = IF_UJ;
        else begin f = IF_R; il = 1'b1; end
    endfunction

    function automatic mdl_t m_next(mdl_t s, int k);
        mdl_t n;
        logic rq;
        logic [31:0] w;
        n = s;
        if (rst) begin
            n = '0;
            n.boot = 1'b1;
            n.pc = (k == 0) ? RPC0 : RPC1;
            n.fmt = IF_R;
            return n;
        end
        rq = m_req(s);
        n.boot = 1'b0;
        if (redir) begin
            n.valid = 1'b0;
            if (rq && !ready) begin n.drain = 1'b1; n.saved = rpc & ~32'd3; end
            else begin n.drain = 1'b0; n.pc = rpc & ~32'd3; end
        end else if (s.drain) begin
            if (ready) begin n.drain = 1'b0; n.pc = s.saved; end
            if (!(stall && s.valid)) n.valid = 1'b0;
        end else if (!s.boot && rq && ready) begin
            w = mem_word(k, s.pc);
            n.valid = 1'b1;
            n.inst  = w;
            n.pcout = s.pc;
            classify(w[6:0], n.fmt, n.ill);
            n.pc = s.pc + 32'd4;
        end else if (!(stall && s.valid)) begin
            n.valid = 1'b0;
        end
        return n;
    endfunction

    task automatic cmp_dut(string tag, mdl_t s, logic rq, logic [31:0] ad, logic vl,
                           logic [31:0] in, logic [31:0] pc, logic [2:0] fm, logic il);
        logic erq;
        erq = m_req(s);
        chk({tag, "_req"}, rq, erq);
        if (erq) chk({tag, "_addr"}, ad, s.pc);
        chk({tag, "_valid"}, vl, s.valid);
        if (s.valid) begin
            chk({tag, "_inst"}, in, s.inst);
            chk({tag, "_pcout"}, pc, s.pcout);
            chk({tag, "_fmt"}, fm, s.fmt);
            chk({tag, "_ill"}, il, s.ill);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            m0 = m_next(m0, 0);
            m1 = m_next(m1, 1);
            @(negedge clk);
            #2;
            cmp_dut("m0", m0, req0, addr0, v0, inst0, pco0, fmt0, ill0);
            cmp_dut("m1", m1, req1, addr1, v1, inst1, pco1, fmt1, ill1);
        end
    end

    initial begin
        rst = 1'b1; ready = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("boot_req0", req0, 1'b0);
        chk("boot_req1", req1, 1'b0);
        chk("rst_valid", v0, 1'b0);
        chk("rst_inst", inst0, 32'd0);
        chk("rst_pcout", pco0, 32'd0);
        chk("rst_fmt", fmt0, IF_R);
        chk("rst_ill", ill0, 1'b0);
        @(negedge clk); #1;
        chk("run_req", req0, 1'b1);
        chk("run_addr", addr0, 32'h0);
        @(negedge clk); #1;
        chk("s1_valid", v0, 1'b1);
        chk("s1_inst", inst0, 32'h0050_0093);
        chk("s1_pcout", pco0, 32'h0);
        chk("s1_fmt", fmt0, IF_I);
        chk("w1_inst", inst1, 32'h0000_006F);
        chk("w1_fmt", fmt1, IF_UJ);
        chk("w1_pcout", pco1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("s2_inst", inst0, 32'h0020_8133);
        chk("s2_pcout", pco0, 32'h4);
        chk("s2_fmt", fmt0, IF_R);
        chk("w2_pcout", pco1, 32'h0);
        chk("w2_ill", ill1, 1'b1);
        chk("w2_fmt", fmt1, IF_R);
        @(negedge clk); #1;
        chk("s3_inst", inst0, 32'h00A1_2023);
        chk("s3_fmt", fmt0, IF_S);
        stall = 1'b1; #1;
        chk("stall_req", req0, 1'b0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("stall_inst", inst0, 32'h00A1_2023);
            chk("stall_valid", v0, 1'b1);
            chk("stall_fmt", fmt0, IF_S);
            chk("stall_req", req0, 1'b0);
            chk("stall_addr", addr0, 32'hC);
        end
        stall = 1'b0; #1;
        chk("rel_req", req0, 1'b1);
        chk("rel_addr", addr0, 32'hC);
        @(negedge clk); #1;
        chk("rel_pcout", pco0, 32'hC);
        chk("rel_valid", v0, 1'b1);
        redir = 1'b1; rpc = 32'h0000_0102;
        @(negedge clk); redir = 1'b0; #1;
        chk("rdr_valid", v0, 1'b0);
        chk("rdr_addr", addr0, 32'h100);
        chk("rdr_req", req0, 1'b1);
        redir = 1'b1; rpc = 32'h20;
        @(negedge clk); redir = 1'b0; ready = 1'b0; #1;
        chk("wait0_addr", addr0, 32'h20);
        @(negedge clk); redir = 1'b1; rpc = 32'h80; #1;
        chk("wait1_addr", addr0, 32'h20);
        @(negedge clk); redir = 1'b0; #1;
        chk("wait2_addr", addr0, 32'h20);
        chk("wait2_valid", v0, 1'b0);
        @(negedge clk); #1;
        chk("wait3_addr", addr0, 32'h20);
        @(negedge clk); ready = 1'b1; #1;
        chk("wait4_addr", addr0, 32'h20);
        chk("wait4_req", req0, 1'b1);
        @(negedge clk); #1;
        chk("drn_addr", addr0, 32'h80);
        chk("drn_valid", v0, 1'b0);
        @(negedge clk); #1;
        chk("drn_valid2", v0, 1'b1);
        chk("drn_pcout", pco0, 32'h80);
        ready = 1'b0; redir = 1'b1; rpc = 32'h40;
        @(negedge clk); redir = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("rstd_valid", v0, 1'b0);
        chk("rstd_req", req0, 1'b0);
        ready = 1'b1;
        @(negedge clk); #1;
        chk("rstd_addr0", addr0, 32'h0);
        chk("rstd_addr1", addr1, 32'hFFFF_FFFC);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 11) == 0);
            rpc   = ($urandom_range(0, 1) == 0) ? $urandom : {24'd0, 8'($urandom)};
            rst   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the immediate generator.
- Owns the PC and runs a req/ready handshake with instruction memory.
- Holds the fetched word in an IF/ID output register with valid, stall and flush control.
- Pre-classifies the opcode into the shared InstFormat code, so the immediate generator and the rest of decode consume `inst_out` and `InstFormat` from one registered source.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always word-aligned.
- imem_ready  in  1  memory accepts request and returns `imem_rdata` in the same cycle.
- imem_rdata  in  32  instruction word; valid only when `imem_req && imem_ready`.
- stall_in  in  1  downstream cannot accept; hold the output register.
- redirect_valid  in  1  branch/jump redirect; also flushes the output register.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  output register holds a live instruction.
- inst_out  out  32  registered instruction word.
- pc_out  out  32  PC of `inst_out`.
- InstFormat  out  3  registered format code (IFormatR/I/S/SB/U/UJ from the shared parameters header).
- illegal_op  out  1  registered; opcode not in the table below.

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_PC; state <= BOOT.
  - inst_valid, illegal_op <= 0; inst_out, pc_out <= 0; InstFormat <= IFormatR.
  - Reset mid-transaction abandons it; the pending response is never captured.
- State machine (3 states):
  - BOOT: imem_req=0 for exactly one cycle, then -> RUN.
  - RUN:
    - imem_req = !inst_valid || !stall_in; imem_addr = pc.
    - Accept = imem_req && imem_ready: inst_out <= imem_rdata, pc_out <= pc, inst_valid <= 1, format/illegal decoded from imem_rdata[6:0], pc <= pc + 4.
    - PC increment is mod 2^32: 32'hFFFF_FFFC -> 0.
  - DRAIN:
    - Entered on a redirect while imem_req=1 and imem_ready=0.
    - imem_req held 1 and imem_addr held at the old pc; a request, once raised, keeps addr stable until ready.
    - When imem_ready=1, the response is discarded, pc <= saved redirect target, -> RUN.
    - A further redirect in DRAIN overwrites the saved target.
- Output register with no accept:
  - stall_in=1 and inst_valid=1: all outputs hold.
  - Otherwise (no stall, or inst_valid=0): inst_valid <= 0.
- Redirect has highest priority:
  - inst_valid <= 0 that cycle; any same-cycle accepted response is discarded.
  - Target is {redirect_pc[31:2],2'b00}.
  - If imem_req=0 or imem_ready=1: pc <= target, stay/return RUN.
  - Otherwise: save target, -> DRAIN.
- Redirect and stall asserted together: redirect wins (flush).
- Throughput: one instruction per cycle when imem_ready=1 and stall_in=0; inst_out appears the cycle after acceptance.
- Format table (opcode[6:0] -> InstFormat):
  - 0110011 -> R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> SB.
  - 0110111, 0010111 -> U.
  - 1101111 -> UJ.
  - Any other opcode -> IFormatR with illegal_op=1.

Test Plan:
- Reset and stream: rst 2 cycles, imem_ready=1, memory returns 32'h00500093 at 0x0 and 32'h00208133 at 0x4.
  - imem_req low for 1 cycle after reset.
  - Then inst_out=32'h00500093, pc_out=0, InstFormat=IFormatI; next cycle 32'h00208133, pc_out=4, IFormatR.
- Stall: assert stall_in for 3 cycles while inst_valid=1 holding 32'h00A12023 (S).
  - Outputs frozen; imem_req=0 during stall; pc unchanged.
  - On release the next word is fetched from the held pc.
- Redirect, memory ready: redirect_valid with redirect_pc=32'h0000_0102 while imem_ready=1.
  - inst_valid=0 next cycle; next imem_addr=32'h0000_0100; same-cycle response discarded.
- Redirect during wait: imem_ready=0 for 4 cycles at addr 0x20, redirect to 0x80 in cycle 1.
  - imem_addr stays 0x20 until ready; that response never appears on inst_out.
  - Next request addr=0x80, inst_valid=1 with pc_out=0x80.
- Wrap and illegal: RESET_PC=32'hFFFF_FFFC, memory returns 32'h0000006F then 32'h0000007F.
  - First: InstFormat=IFormatUJ, pc_out=FFFF_FFFC.
  - Second: pc_out=0, illegal_op=1, InstFormat=IFormatR.
- Reset mid-DRAIN: rst asserted while in DRAIN.
  - Next cycle inst_valid=0, imem_req=0 (BOOT), then fetch resumes at RESET_PC.
